// File: rtl/cordic_pkg.sv
// Shared types, sizes and constants for the iterative CORDIC engine.
// Imported by cordic_iter and its angle table.
package cordic_pkg;

    localparam int DW            = 17;
    localparam int GUARD         = 2;
    localparam int IW            = DW + GUARD;
    localparam int IDX_W         = 5;
    localparam int CORDIC_N_ITER = 16;
    localparam int HYP_REPEAT_0  = 4;
    localparam int HYP_REPEAT_1  = 13;

    typedef enum logic {
        ROTATION,
        VECTORING
    } mode_t;

    typedef enum logic [1:0] {
        CIRCULAR,
        LINEAR,
        HYPERBOLIC
    } coord_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Pre-scale that cancels the rotation gain, with 1.0 == 0x4000
    function automatic logic [DW-1:0] cordic_gain_inv(input coord_t c);
        logic [DW-1:0] g;
        case (c)
            CIRCULAR:   g = 17'h026DD;
            HYPERBOLIC: g = 17'h04D48;
            default:    g = 17'h04000;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/cordic_angle_rom.sv
// Micro-rotation angle e(i) for each coordinate system.
// Values already carry the internal guard bits.
module cordic_angle_rom
    import cordic_pkg::*;
(
    input  coord_t           i_coord,
    input  logic [IDX_W-1:0] i_idx,
    output logic [IW-1:0]    o_e
);

    localparam logic [IW-1:0] LIN_ONE = 19'h08000;

    logic [IW-1:0] w_atan;
    logic [IW-1:0] w_atanh;
    logic [IW-1:0] w_lin;

    // atan(2^-i), 2*pi == 2^19 internally
    always_comb begin
        w_atan = '0;
        case (i_idx)
            5'd0:    w_atan = 19'd65536;
            5'd1:    w_atan = 19'd38688;
            5'd2:    w_atan = 19'd20442;
            5'd3:    w_atan = 19'd10377;
            5'd4:    w_atan = 19'd5208;
            5'd5:    w_atan = 19'd2607;
            5'd6:    w_atan = 19'd1304;
            5'd7:    w_atan = 19'd652;
            5'd8:    w_atan = 19'd326;
            5'd9:    w_atan = 19'd163;
            5'd10:   w_atan = 19'd81;
            5'd11:   w_atan = 19'd41;
            5'd12:   w_atan = 19'd20;
            5'd13:   w_atan = 19'd10;
            5'd14:   w_atan = 19'd5;
            5'd15:   w_atan = 19'd3;
            5'd16:   w_atan = 19'd1;
            5'd17:   w_atan = 19'd1;
            default: w_atan = '0;
        endcase
    end

    // atanh(2^-i), 1.0 == 0x8000 internally
    always_comb begin
        w_atanh = '0;
        case (i_idx)
            5'd1:    w_atanh = 19'd18000;
            5'd2:    w_atanh = 19'd8369;
            5'd3:    w_atanh = 19'd4118;
            5'd4:    w_atanh = 19'd2051;
            5'd5:    w_atanh = 19'd1024;
            5'd6:    w_atanh = 19'd512;
            5'd7:    w_atanh = 19'd256;
            5'd8:    w_atanh = 19'd128;
            5'd9:    w_atanh = 19'd64;
            5'd10:   w_atanh = 19'd32;
            5'd11:   w_atanh = 19'd16;
            5'd12:   w_atanh = 19'd8;
            5'd13:   w_atanh = 19'd4;
            5'd14:   w_atanh = 19'd2;
            5'd15:   w_atanh = 19'd1;
            default: w_atanh = '0;
        endcase
    end

    assign w_lin = LIN_ONE >> i_idx;

    always_comb begin
        o_e = w_lin;
        case (i_coord)
            CIRCULAR:   o_e = w_atan;
            HYPERBOLIC: o_e = w_atanh;
            default:    o_e = w_lin;
        endcase
    end

endmodule

// File: rtl/cordic_iter.sv
// Iterative CORDIC engine: one micro-rotation per clock, one op in flight,
// valid/ready on both sides with the FP sideband carried alongside.
module cordic_iter
    import cordic_pkg::*;
#(
    parameter int N_ITER = CORDIC_N_ITER
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  mode_t         in_mode,
    input  coord_t        in_coord,
    input  logic [DW-1:0] in_x,
    input  logic [DW-1:0] in_y,
    input  logic [DW-1:0] in_z,
    input  logic          in_sign,
    input  logic [6:0]    in_exp,
    input  logic          in_ovr,
    input  logic [17:0]   in_ovr_val,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_x,
    output logic [DW-1:0] out_y,
    output logic [DW-1:0] out_z,
    output logic          out_sign,
    output logic [6:0]    out_exp,
    output logic          out_ovr,
    output logic [17:0]   out_ovr_val
);

    state_t r_state;
    state_t w_state_nx;
    logic   r_live;
    mode_t  r_mode;
    coord_t r_coord;

    logic signed [IW-1:0] r_x;
    logic signed [IW-1:0] r_y;
    logic signed [IW-1:0] r_z;
    logic signed [IW-1:0] w_xs;
    logic signed [IW-1:0] w_ys;
    logic signed [IW-1:0] w_xn;
    logic signed [IW-1:0] w_yn;
    logic signed [IW-1:0] w_zn;
    logic [IW-1:0]        w_e;

    logic [IDX_W-1:0] r_i;
    logic [IDX_W-1:0] r_cnt;
    logic [IDX_W-1:0] w_total;
    logic             r_rep;
    logic             w_acc;
    logic             w_d;
    logic             w_last;
    logic             w_hold;

    logic        r_sign;
    logic [6:0]  r_exp;
    logic        r_ovr;
    logic [17:0] r_ovr_val;

    // r_live keeps in_ready low until the first edge out of reset
    assign in_ready = r_live & ((r_state == IDLE) |
                      ((r_state == DONE) & out_ready));
    assign w_acc    = in_valid & in_ready;

    assign w_total = (r_coord == HYPERBOLIC) ?
                     IDX_W'(N_ITER + 2) : IDX_W'(N_ITER);
    assign w_last  = (r_cnt == w_total - IDX_W'(1));
    assign w_hold  = (r_coord == HYPERBOLIC) & ~r_rep &
                     ((r_i == IDX_W'(HYP_REPEAT_0)) |
                      (r_i == IDX_W'(HYP_REPEAT_1)));

    cordic_angle_rom u_rom (
        .i_coord (r_coord),
        .i_idx   (r_i),
        .o_e     (w_e)
    );

    assign w_d  = (r_mode == ROTATION) ? ~r_z[IW-1] : r_y[IW-1];
    assign w_xs = r_x >>> r_i;
    assign w_ys = r_y >>> r_i;
    assign w_yn = w_d ? r_y + w_xs : r_y - w_xs;
    assign w_zn = w_d ? r_z - $signed(w_e) : r_z + $signed(w_e);

    always_comb begin
        w_xn = r_x;
        unique case (1'b1)
            r_coord == CIRCULAR:   w_xn = w_d ? r_x - w_ys : r_x + w_ys;
            r_coord == HYPERBOLIC: w_xn = w_d ? r_x + w_ys : r_x - w_ys;
            default:               w_xn = r_x;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: if (w_acc) w_state_nx = in_ovr ? DONE : RUN;
            RUN:  if (w_last) w_state_nx = DONE;
            DONE: if (out_ready)
                      w_state_nx = !w_acc ? IDLE : (in_ovr ? DONE : RUN);
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_live  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode    <= ROTATION;
            r_coord   <= CIRCULAR;
            r_x       <= '0;
            r_y       <= '0;
            r_z       <= '0;
            r_i       <= '0;
            r_cnt     <= '0;
            r_rep     <= 1'b0;
            r_sign    <= 1'b0;
            r_exp     <= '0;
            r_ovr     <= 1'b0;
            r_ovr_val <= '0;
        end else if (w_acc) begin
            r_mode    <= in_mode;
            r_coord   <= in_coord;
            r_x       <= in_ovr ? '0 : {in_x, {GUARD{1'b0}}};
            r_y       <= in_ovr ? '0 : {in_y, {GUARD{1'b0}}};
            r_z       <= in_ovr ? '0 : {in_z, {GUARD{1'b0}}};
            r_i       <= (in_coord == HYPERBOLIC) ? IDX_W'(1) : '0;
            r_cnt     <= '0;
            r_rep     <= 1'b0;
            r_sign    <= in_sign;
            r_exp     <= in_exp;
            r_ovr     <= in_ovr;
            r_ovr_val <= in_ovr_val;
        end else if (r_state == RUN) begin
            r_x   <= w_xn;
            r_y   <= w_yn;
            r_z   <= w_zn;
            r_cnt <= r_cnt + IDX_W'(1);
            if (w_hold) begin
                r_rep <= 1'b1;
            end else begin
                r_rep <= 1'b0;
                r_i   <= r_i + IDX_W'(1);
            end
        end
    end

    assign out_valid   = (r_state == DONE);
    assign out_x       = r_x[IW-1:GUARD];
    assign out_y       = r_y[IW-1:GUARD];
    assign out_z       = r_z[IW-1:GUARD];
    assign out_sign    = r_sign;
    assign out_exp     = r_exp;
    assign out_ovr     = r_ovr;
    assign out_ovr_val = r_ovr_val;

endmodule

// File: tb/tb_cordic_iter.sv
// Directed bench for cordic_iter: hand-computed results with LSB tolerance,
// latency, sideband, override hold, back-to-back accept and async reset.
module tb_cordic_iter;
    import cordic_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    mode_t         in_mode;
    coord_t        in_coord;
    logic [DW-1:0] in_x, in_y, in_z;
    logic          in_sign;
    logic [6:0]    in_exp;
    logic          in_ovr;
    logic [17:0]   in_ovr_val;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_x, out_y, out_z;
    logic          out_sign;
    logic [6:0]    out_exp;
    logic          out_ovr;
    logic [17:0]   out_ovr_val;

    int n_chk = 0;
    int n_err = 0;
    int lat;

    always #5 clk = ~clk;

    cordic_iter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mode     (in_mode),
        .in_coord    (in_coord),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_z        (in_z),
        .in_sign     (in_sign),
        .in_exp      (in_exp),
        .in_ovr      (in_ovr),
        .in_ovr_val  (in_ovr_val),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_z       (out_z),
        .out_sign    (out_sign),
        .out_exp     (out_exp),
        .out_ovr     (out_ovr),
        .out_ovr_val (out_ovr_val)
    );

    task automatic chk(input string tag, input int got,
                       input int exp, input int tol);
        n_chk++;
        if (got > exp + tol || got < exp - tol) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d +/- %0d",
                     tag, got, got, exp, tol);
        end
    endtask

    function automatic int sx(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic drive(input mode_t m, input coord_t c,
                         input int x, input int y, input int z,
                         input logic ovr, input logic [17:0] ov,
                         input logic s, input logic [6:0] e);
        in_mode    = m;
        in_coord   = c;
        in_x       = DW'(x);
        in_y       = DW'(y);
        in_z       = DW'(z);
        in_ovr     = ovr;
        in_ovr_val = ov;
        in_sign    = s;
        in_exp     = e;
        in_valid   = 1'b1;
    endtask

    task automatic start(input mode_t m, input coord_t c,
                         input int x, input int y, input int z,
                         input logic ovr, input logic [17:0] ov,
                         input logic s, input logic [6:0] e);
        int n;
        @(negedge clk);
        drive(m, c, x, y, z, ovr, ov, s, e);
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1, 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(output int l);
        l = 1;
        while (!out_valid && l < 60) begin
            @(posedge clk);
            #1;
            l++;
        end
        if (!out_valid) chk("done_timeout", 0, 1, 0);
    endtask

    task automatic pop();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(ROTATION, CIRCULAR, 0, 0, 0, 1'b0, '0, 1'b0, '0);
        in_valid  = 1'b0;

        #12;
        chk("rst_valid", out_valid, 0, 0);
        chk("rst_ready", in_ready, 0, 0);
        chk("rst_x", sx(out_x), 0, 0);
        chk("rst_ovr_val", out_ovr_val, 0, 0);
        chk("rst_exp", out_exp, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk("rel_ready", in_ready, 1, 0);

        // x*z = 1.5 * 1.0
        start(ROTATION, LINEAR, 'h3000, 0, 'h2000,
              1'b0, 18'h12345, 1'b1, 7'h2A);
        chk("mul_run_ready", in_ready, 0, 0);
        wait_done(lat);
        chk("mul_lat", lat, 17, 0);
        chk("mul_y", sx(out_y), 'h3000, 2);
        chk("mul_x", sx(out_x), 'h3000, 0);
        chk("mul_sign", out_sign, 1, 0);
        chk("mul_exp", out_exp, 'h2A, 0);
        chk("mul_ovr", out_ovr, 0, 0);
        chk("mul_ovr_val", out_ovr_val, 'h12345, 0);
        pop();
        chk("mul_idle", out_valid, 0, 0);

        // y/x = 0.5
        start(VECTORING, LINEAR, 'h2000, 'h1000, 0,
              1'b0, '0, 1'b0, 7'h01);
        wait_done(lat);
        chk("div_lat", lat, 17, 0);
        chk("div_z", sx(out_z), 'h1000, 2);
        chk("div_y", sx(out_y), 0, 2);
        chk("div_x", sx(out_x), 'h2000, 0);
        pop();

        // rotate 1/K by pi/4
        start(ROTATION, CIRCULAR, 'h26DD, 0, 'h4000,
              1'b0, '0, 1'b0, '0);
        wait_done(lat);
        chk("c45_lat", lat, 17, 0);
        chk("c45_x", sx(out_x), 'h2D41, 4);
        chk("c45_y", sx(out_y), 'h2D41, 4);
        chk("c45_z", sx(out_z), 0, 2);
        pop();

        start(ROTATION, CIRCULAR, 'h26DD, 0, 0,
              1'b0, '0, 1'b0, '0);
        wait_done(lat);
        chk("c0_x", sx(out_x), 'h4000, 4);
        chk("c0_y", sx(out_y), 0, 4);
        pop();

        // K_h * sqrt(x^2 - y^2)
        start(VECTORING, HYPERBOLIC, 'h3754, 'h08AC, 0,
              1'b0, '0, 1'b0, '0);
        wait_done(lat);
        chk("hyp_lat", lat, 19, 0);
        chk("hyp_x", sx(out_x), 'h2D41, 8);
        chk("hyp_y", sx(out_y), 0, 4);
        pop();

        // override, held output, then back-to-back accept
        start(ROTATION, CIRCULAR, 'h1234, 'h1234, 'h1234,
              1'b1, 18'h3FE00, 1'b1, 7'h55);
        wait_done(lat);
        chk("ovr_lat", lat, 1, 0);
        chk("ovr_x", sx(out_x), 0, 0);
        chk("ovr_z", sx(out_z), 0, 0);
        chk("ovr_val", out_ovr_val, 'h3FE00, 0);
        chk("ovr_flag", out_ovr, 1, 0);
        chk("ovr_sign", out_sign, 1, 0);
        chk("ovr_exp", out_exp, 'h55, 0);
        @(negedge clk);
        drive(ROTATION, LINEAR, 'h3000, 0, 'h2000,
              1'b0, 18'h00ABC, 1'b0, 7'h11);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", out_valid, 1, 0);
            chk("hold_ovr_val", out_ovr_val, 'h3FE00, 0);
            chk("hold_y", sx(out_y), 0, 0);
            chk("hold_ready", in_ready, 0, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1 chk("b2b_ready", in_ready, 1, 0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_run", out_valid, 0, 0);
        wait_done(lat);
        chk("b2b_lat", lat, 17, 0);
        chk("b2b_y", sx(out_y), 'h3000, 2);
        chk("b2b_ovr", out_ovr, 0, 0);
        chk("b2b_ovr_val", out_ovr_val, 'hABC, 0);
        pop();

        // reset in the middle of an operation
        start(ROTATION, LINEAR, 'h3000, 0, 'h2000,
              1'b0, 18'h3FFFF, 1'b1, 7'h7F);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_valid", out_valid, 0, 0);
        chk("mrst_ready", in_ready, 0, 0);
        chk("mrst_y", sx(out_y), 0, 0);
        chk("mrst_ovr_val", out_ovr_val, 0, 0);
        chk("mrst_sign", out_sign, 0, 0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk("mrst_rel_ready", in_ready, 1, 0);

        start(ROTATION, CIRCULAR, 'h26DD, 0, 'h4000,
              1'b0, '0, 1'b0, '0);
        wait_done(lat);
        chk("post_lat", lat, 17, 0);
        chk("post_x", sx(out_x), 'h2D41, 4);
        chk("post_y", sx(out_y), 'h2D41, 4);
        pop();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
